// File: rtl/byte_ram_port.sv
// Byte-addressed single-port RAM with a little-endian multi-byte access window,
// per-byte write enables, wrap-around at the top of memory and a fixed-latency read pipe.
module byte_ram_port #(
  parameter int DATA_BYTES   = 4,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    readReq,
  input  logic                    writeReq,
  input  logic [31:0]             address,
  input  logic [8*DATA_BYTES-1:0] writeData,
  input  logic [DATA_BYTES-1:0]   byteEn,
  output logic [8*DATA_BYTES-1:0] readData,
  output logic                    readValid,
  output logic                    addrError
);

  // Handshake: there is no ready. readReq/writeReq are accepted on every rising
  // edge they are high (reset low); readValid is a one-cycle pulse and readData
  // holds its value until the next pulse.

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DW    = 8 * DATA_BYTES;

  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_idx [DATA_BYTES];
  logic                  w_in_range;
  logic                  w_wr_ok;
  logic [DW-1:0]         w_rd_word;

  logic [READ_LATENCY-1:0] r_pipe_valid;
  logic [DW-1:0]           r_pipe_data [READ_LATENCY];
  logic                    r_read_valid;
  logic [DW-1:0]           r_read_data;
  logic                    r_addr_err;

  assign w_in_range = (address[31:ADDR_WIDTH] == '0);
  assign w_wr_ok    = writeReq & w_in_range & ~reset;

  // Byte lanes index modulo the memory depth, so an access at the top wraps to 0.
  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_idx[i] = address[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_in_range) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        w_rd_word[8*i +: 8] = r_mem[w_idx[i]];
      end
    end
  end

  // Memory has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (byteEn[i]) begin
          r_mem[w_idx[i]] <= writeData[8*i +: 8];
        end
      end
    end
  end

  // Read data is captured at the accepting edge, so a same-edge or later write
  // never changes a word that is already travelling down the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_data[i] <= '0;
      end
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      r_pipe_valid[0] <= readReq;
      r_pipe_data[0]  <= readReq ? w_rd_word : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_data[i]  <= r_pipe_data[i-1];
      end
      r_read_valid <= r_pipe_valid[READ_LATENCY-1];
      if (r_pipe_valid[READ_LATENCY-1]) begin
        r_read_data <= r_pipe_data[READ_LATENCY-1];
      end
      r_addr_err <= (readReq | writeReq) & ~w_in_range;
    end
  end

  assign readData  = r_read_data;
  assign readValid = r_read_valid;
  assign addrError = r_addr_err;

endmodule

// File: tb/tb_byte_ram_port.sv
// Directed bench for byte_ram_port: three instances (read latency 1, 3, 4) share
// one stimulus stream; each scenario task checks the instance it targets.
module tb_byte_ram_port;

  logic        clk;
  logic        reset;
  logic        readReq;
  logic        writeReq;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  byteEn;

  logic [31:0] rd_data_l1, rd_data_l3, rd_data_l4;
  logic        rd_valid_l1, rd_valid_l3, rd_valid_l4;
  logic        addr_err_l1, addr_err_l3, addr_err_l4;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  byte_ram_port #(.DATA_BYTES(4), .ADDR_WIDTH(11), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
    .address(address), .writeData(writeData), .byteEn(byteEn),
    .readData(rd_data_l1), .readValid(rd_valid_l1), .addrError(addr_err_l1)
  );

  byte_ram_port #(.DATA_BYTES(4), .ADDR_WIDTH(11), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
    .address(address), .writeData(writeData), .byteEn(byteEn),
    .readData(rd_data_l3), .readValid(rd_valid_l3), .addrError(addr_err_l3)
  );

  byte_ram_port #(.DATA_BYTES(4), .ADDR_WIDTH(11), .READ_LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
    .address(address), .writeData(writeData), .byteEn(byteEn),
    .readData(rd_data_l4), .readValid(rd_valid_l4), .addrError(addr_err_l4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drivers: inputs change on the falling edge, outputs are sampled there too
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    readReq   = rd;
    writeReq  = wr;
    address   = addr;
    writeData = data;
    byteEn    = be;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      readReq  = 1'b0;
      writeReq = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    readReq   = 1'b1;
    writeReq  = 1'b1;
    address   = 32'h0000_0800;
    writeData = 32'h1234_5678;
    byteEn    = 4'hF;
    repeat (3) @(negedge clk);
    n_vec++; if (rd_valid_l1 !== 1'b0) begin n_err++; $display("FAIL reset_valid_l1: got %b want 0", rd_valid_l1); end
    n_vec++; if (rd_data_l1 !== 32'h0) begin n_err++; $display("FAIL reset_data_l1: got %h want 00000000", rd_data_l1); end
    n_vec++; if (addr_err_l1 !== 1'b0) begin n_err++; $display("FAIL reset_adderr_l1: got %b want 0", addr_err_l1); end
    n_vec++; if (rd_valid_l4 !== 1'b0) begin n_err++; $display("FAIL reset_valid_l4: got %b want 0", rd_valid_l4); end
    n_vec++; if (addr_err_l4 !== 1'b0) begin n_err++; $display("FAIL reset_adderr_l4: got %b want 0", addr_err_l4); end
  endtask

  task automatic test_basic;
    // reset is released on the same falling edge the first write is set up
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    n_vec++; if (addr_err_l1 !== 1'b0) begin n_err++; $display("FAIL basic_adderr: got %b want 0", addr_err_l1); end
    idle_cycles(1);
    n_vec++; if (rd_valid_l1 !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", rd_valid_l1); end
    idle_cycles(1);
    n_vec++; if (rd_valid_l1 !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", rd_valid_l1); end
    n_vec++; if (rd_data_l1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_data: got %h want deadbeef", rd_data_l1); end
    n_vec++; if (u_l1.r_mem[16] !== 8'hEF) begin n_err++; $display("FAIL basic_mem10: got %h want ef", u_l1.r_mem[16]); end
    idle_cycles(1);
    n_vec++; if (rd_valid_l1 !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %b want 0", rd_valid_l1); end
    n_vec++; if (rd_data_l1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_hold: got %h want deadbeef", rd_data_l1); end
    idle_cycles(4);
  endtask

  task automatic test_byte_enable;
    drive(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
    drive(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0101);
    drive(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    n_vec++; if (addr_err_l1 !== 1'b0) begin n_err++; $display("FAIL be_noop_adderr: got %b want 0", addr_err_l1); end
    idle_cycles(2);
    n_vec++; if (rd_valid_l1 !== 1'b1) begin n_err++; $display("FAIL be_valid: got %b want 1", rd_valid_l1); end
    n_vec++; if (rd_data_l1 !== 32'hAA22CC44) begin n_err++; $display("FAIL be_data: got %h want aa22cc44", rd_data_l1); end
    idle_cycles(4);
  endtask

  task automatic test_wrap;
    drive(1'b0, 1'b1, 32'h7FE, 32'h01020304, 4'hF);
    drive(1'b1, 1'b0, 32'h7FE, 32'h0, 4'h0);
    n_vec++; if (addr_err_l1 !== 1'b0) begin n_err++; $display("FAIL wrap_adderr: got %b want 0", addr_err_l1); end
    idle_cycles(2);
    n_vec++; if (rd_data_l1 !== 32'h01020304) begin n_err++; $display("FAIL wrap_top: got %h want 01020304", rd_data_l1); end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idle_cycles(2);
    n_vec++; if (rd_valid_l1 !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", rd_valid_l1); end
    n_vec++; if (rd_data_l1[15:0] !== 16'h0102) begin n_err++; $display("FAIL wrap_bottom: got %h want 0102", rd_data_l1[15:0]); end
    idle_cycles(4);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w;
    drive(1'b0, 1'b1, 32'h0, 32'h00C0FFEE, 4'hF);
    drive(1'b0, 1'b1, 32'h4, 32'h44444444, 4'hF);
    drive(1'b0, 1'b1, 32'h8, 32'h88888888, 4'hF);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h4, 32'h55555555, 4'hF);
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    exp_q.push_back(32'h00C0FFEE);
    exp_q.push_back(32'h44444444);
    exp_q.push_back(32'h88888888);
    // overwrite 0x8 right after its read was accepted
    drive(1'b0, 1'b1, 32'h8, 32'h99999999, 4'hF);
    n_vec++; if (rd_valid_l3 !== 1'b0) begin n_err++; $display("FAIL b2b_early_valid: got %b want 0", rd_valid_l3); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      readReq  = 1'b0;
      writeReq = 1'b0;
      n_vec++;
      if (rd_valid_l3 !== (k <= 3)) begin
        n_err++; $display("FAIL b2b_valid_k%0d: got %b want %b", k, rd_valid_l3, (k <= 3));
      end
      if (rd_valid_l3 === 1'b1 && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        n_vec++;
        if (rd_data_l3 !== exp_w) begin n_err++; $display("FAIL b2b_data_k%0d: got %h want %h", k, rd_data_l3, exp_w); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle_cycles(4);
    n_vec++; if (rd_valid_l3 !== 1'b1) begin n_err++; $display("FAIL b2b_reread_valid: got %b want 1", rd_valid_l3); end
    n_vec++; if (rd_data_l3 !== 32'h99999999) begin n_err++; $display("FAIL b2b_reread_data: got %h want 99999999", rd_data_l3); end
    idle_cycles(4);
  endtask

  task automatic test_addr_error;
    drive(1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
    idle_cycles(1);
    n_vec++; if (addr_err_l1 !== 1'b1) begin n_err++; $display("FAIL oor_rd_adderr: got %b want 1", addr_err_l1); end
    idle_cycles(1);
    n_vec++; if (rd_valid_l1 !== 1'b1) begin n_err++; $display("FAIL oor_rd_valid: got %b want 1", rd_valid_l1); end
    n_vec++; if (rd_data_l1 !== 32'h0) begin n_err++; $display("FAIL oor_rd_data: got %h want 00000000", rd_data_l1); end
    n_vec++; if (addr_err_l1 !== 1'b0) begin n_err++; $display("FAIL oor_rd_pulse: got %b want 0", addr_err_l1); end
    drive(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    idle_cycles(1);
    n_vec++; if (addr_err_l1 !== 1'b1) begin n_err++; $display("FAIL oor_wr_adderr: got %b want 1", addr_err_l1); end
    drive(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'h0);
    idle_cycles(1);
    n_vec++; if (addr_err_l1 !== 1'b1) begin n_err++; $display("FAIL oor_wr_be0_adderr: got %b want 1", addr_err_l1); end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idle_cycles(2);
    n_vec++; if (rd_data_l1 !== 32'h00C0FFEE) begin n_err++; $display("FAIL oor_wr_mem: got %h want 00c0ffee", rd_data_l1); end
    idle_cycles(4);
  endtask

  task automatic test_reset_flush;
    drive(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    idle_cycles(2);
    reset = 1'b1;
    #1;
    n_vec++; if (rd_valid_l4 !== 1'b0) begin n_err++; $display("FAIL flush_rst_valid: got %b want 0", rd_valid_l4); end
    n_vec++; if (rd_data_l4 !== 32'h0) begin n_err++; $display("FAIL flush_rst_data: got %h want 00000000", rd_data_l4); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++;
      if (rd_valid_l4 !== 1'b0) begin n_err++; $display("FAIL flush_ghost_k%0d: got %b want 0", k, rd_valid_l4); end
    end
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    idle_cycles(5);
    n_vec++; if (rd_valid_l4 !== 1'b1) begin n_err++; $display("FAIL flush_after_valid: got %b want 1", rd_valid_l4); end
    n_vec++; if (rd_data_l4 !== 32'hCAFEF00D) begin n_err++; $display("FAIL flush_after_data: got %h want cafef00d", rd_data_l4); end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_wrap();
    test_back_to_back();
    test_addr_error();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
